// File: rtl/dma_desc_sched_if.sv
// Descriptor-scheduler bus: queue heads and pop strobes on one side, the
// DMA engine handshake, the grant and the busy flag on the other.
interface dma_desc_sched_if #(
  parameter int NUM_CHN = 4,
  parameter int CHN_W   = 2
);
  logic [NUM_CHN-1:0]    i_fifo_empty;
  logic [17*NUM_CHN-1:0] i_fifo_dout;
  logic [NUM_CHN-1:0]    o_fifo_rd;
  logic                  o_desc_valid;
  logic [16:0]           o_desc_data;
  logic [CHN_W-1:0]      o_desc_chn;
  logic                  i_desc_ready;
  logic                  i_dma_done;
  logic [NUM_CHN-1:0]    o_grant;
  logic                  o_busy;

  modport master (
    input  i_fifo_empty, i_fifo_dout, i_desc_ready, i_dma_done,
    output o_fifo_rd, o_desc_valid, o_desc_data, o_desc_chn, o_grant, o_busy
  );

  modport slave (
    output i_fifo_empty, i_fifo_dout, i_desc_ready, i_dma_done,
    input  o_fifo_rd, o_desc_valid, o_desc_data, o_desc_chn, o_grant, o_busy
  );
endinterface

// File: rtl/dma_desc_sched.sv
// Round-robin DMA descriptor scheduler with per-packet channel lock.
// Optional per-channel byte counters: define DMA_SCHED_STAT_EN.
module dma_desc_sched #(
  parameter int NUM_CHN = 4,
  parameter int CHN_W   = 2
) (
  input  logic clk,
  input  logic rst_n,
  dma_desc_sched_if.master bus
`ifdef DMA_SCHED_STAT_EN
  ,
  output logic [NUM_CHN*32-1:0] o_stat_bytes
`endif
);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT_DONE, HOLD} state_t;

  state_t           state_q, state_d;
  logic [CHN_W-1:0] chn_q, chn_d;
  logic [CHN_W-1:0] rr_q, rr_d;
  logic             lock_q, lock_d;
  logic [16:0]      data_q, data_d;

  logic [NUM_CHN-1:0] rd;
  logic [16:0]        head;
  logic               grant_empty;
  logic [CHN_W-1:0]   chn_nxt;
  logic               sel_found;
  logic [CHN_W-1:0]   sel_chn;

  assign head        = bus.i_fifo_dout[17*int'(chn_q) +: 17];
  assign grant_empty = bus.i_fifo_empty[chn_q];
  assign chn_nxt     = (chn_q == CHN_W'(NUM_CHN-1)) ? '0 : chn_q + 1'b1;

  // Walk downward from the farthest offset so the nearest non-empty queue
  // past rr_q is the one left in sel_chn.
  always_comb begin
    sel_found = 1'b0;
    sel_chn   = '0;
    for (int i = NUM_CHN-1; i >= 0; i--) begin
      if (!bus.i_fifo_empty[(int'(rr_q) + i) % NUM_CHN]) begin
        sel_found = 1'b1;
        sel_chn   = CHN_W'((int'(rr_q) + i) % NUM_CHN);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    chn_d   = chn_q;
    rr_d    = rr_q;
    lock_d  = lock_q;
    data_d  = data_q;
    rd      = '0;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          chn_d   = sel_chn;
          lock_d  = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        rd[chn_q] = 1'b1;
        data_d    = head;
        if (head[15:0] == 16'd0) begin
          // Zero-length entry is dropped. The empty flag still reflects the
          // entry being popped, so a non-last drop re-checks from HOLD.
          if (head[16]) begin
            lock_d  = 1'b0;
            rr_d    = chn_nxt;
            state_d = IDLE;
          end else begin
            state_d = HOLD;
          end
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.i_desc_ready) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.i_dma_done) begin
          if (data_q[16]) begin
            lock_d  = 1'b0;
            rr_d    = chn_nxt;
            state_d = IDLE;
          end else if (!grant_empty) begin
            state_d = FETCH;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (!grant_empty) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      chn_q   <= '0;
      rr_q    <= '0;
      lock_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      chn_q   <= chn_d;
      rr_q    <= rr_d;
      lock_q  <= lock_d;
      data_q  <= data_d;
    end
  end

  assign bus.o_fifo_rd    = rd;
  assign bus.o_desc_valid = (state_q == ISSUE);
  assign bus.o_desc_data  = data_q;
  assign bus.o_desc_chn   = chn_q;
  assign bus.o_grant      = lock_q ? (NUM_CHN'(1) << chn_q) : '0;
  assign bus.o_busy       = (state_q != IDLE);

`ifdef DMA_SCHED_STAT_EN
  logic                     stat_add;
  logic [NUM_CHN-1:0][31:0] stat_q;

  assign stat_add = (state_q == WAIT_DONE) && bus.i_dma_done;

  for (genvar k = 0; k < NUM_CHN; k++) begin : g_stat
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        stat_q[k] <= '0;
      else if (stat_add && (int'(chn_q) == k))
        stat_q[k] <= stat_q[k] + {16'd0, data_q[15:0]};
    end
  end

  assign o_stat_bytes = stat_q;
`endif

endmodule

// File: tb/tb_dma_desc_sched.sv
// Directed bench for dma_desc_sched: a queue-of-queues FIFO model feeds the
// scheduler; a vector table covers arbitration order, hand sequences the rest.
module tb_dma_desc_sched;
  localparam int N = 4;
  localparam logic [16:0] L8 = 17'h10008;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dma_desc_sched_if #(.NUM_CHN(N), .CHN_W(2)) bus();
`ifdef DMA_SCHED_STAT_EN
  logic [N*32-1:0] stat_bytes;
`endif

  dma_desc_sched #(.NUM_CHN(N), .CHN_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef DMA_SCHED_STAT_EN
    ,
    .o_stat_bytes (stat_bytes)
`endif
  );

  typedef struct {
    int          push_ch;  // -1: no push
    logic [16:0] push_d;
    int          exp_ch;   // -1: no descriptor expected
    logic [16:0] exp_d;
  } vec_t;

  vec_t        tbl[$];
  logic [16:0] q[N][$];
  int          checks = 0;
  int          fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      bus.i_fifo_empty[k]          = (q[k].size() == 0);
      bus.i_fifo_dout[17*k +: 17]  = (q[k].size() != 0) ? q[k][0] : 17'd0;
    end
  endtask

  task automatic push(input int ch, input logic [16:0] d);
    q[ch].push_back(d);
    drive();
  endtask

  // One clock: pops follow the strobes seen before the edge, inputs change at negedge.
  task automatic cyc();
    logic [N-1:0] rd;
    rd = bus.o_fifo_rd;
    @(posedge clk);
    for (int k = 0; k < N; k++) begin
      if (rd[k]) begin
        chk($sformatf("pop_nonempty_q%0d", k), 32'(q[k].size() != 0), 32'd1);
        if (q[k].size() != 0) void'(q[k].pop_front());
      end
    end
    @(negedge clk);
    drive();
  endtask

  task automatic serve(input int ch, input logic [16:0] d, input int dly);
    int n;
    n = 0;
    while (!bus.o_desc_valid && n < 20) begin
      cyc();
      n++;
    end
    chk($sformatf("valid_within_bound_ch%0d", ch), 32'(bus.o_desc_valid), 32'd1);
    chk($sformatf("desc_chn_ch%0d", ch), 32'(bus.o_desc_chn), 32'(ch));
    chk($sformatf("desc_data_ch%0d", ch), 32'(bus.o_desc_data), 32'(d));
    chk($sformatf("grant_ch%0d", ch), 32'(bus.o_grant), 32'(1 << ch));
    cyc();
    chk($sformatf("valid_drop_ch%0d", ch), 32'(bus.o_desc_valid), 32'd0);
    repeat (dly) cyc();
    bus.i_dma_done = 1'b1;
    cyc();
    bus.i_dma_done = 1'b0;
  endtask

  task automatic add(input int pc, input logic [16:0] pd, input int ec, input logic [16:0] ed);
    vec_t v;
    v.push_ch = pc; v.push_d = pd; v.exp_ch = ec; v.exp_d = ed;
    tbl.push_back(v);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, 32'(bus.o_desc_valid), 32'd0);
    chk({tag, "_data"},  32'(bus.o_desc_data),  32'd0);
    chk({tag, "_chn"},   32'(bus.o_desc_chn),   32'd0);
    chk({tag, "_grant"}, 32'(bus.o_grant),      32'd0);
    chk({tag, "_rd"},    32'(bus.o_fifo_rd),    32'd0);
    chk({tag, "_busy"},  32'(bus.o_busy),       32'd0);
  endtask

  initial begin
    // Arbitration table; rr pointer is 1 on entry (after the latency sequence).
    add(0, L8, -1, 0);  add(1, L8, -1, 0);
    add(-1, 0, 1, L8);  add(-1, 0, 0, L8);
    add(3, L8, 3, L8);                        // rotates pointer back to 0
    add(0, L8, -1, 0);  add(1, L8, -1, 0);  add(2, L8, -1, 0);
    add(3, L8, 0, L8);  add(-1, 0, 1, L8);  add(-1, 0, 2, L8);  add(-1, 0, 3, L8);
    add(0, L8, 0, L8);                        // refill queue 0 only
    add(0, L8, -1, 0);  add(2, L8, 2, L8);  add(-1, 0, 0, L8);
    // Lock: both queue-1 descriptors go before queue 2 / queue 0.
    add(1, 17'h00020, -1, 0);  add(1, 17'h10020, -1, 0);
    add(2, 17'h10010, -1, 0);  add(0, L8, 1, 17'h00020);
    add(-1, 0, 1, 17'h10020);  add(-1, 0, 2, 17'h10010);  add(-1, 0, 0, L8);

    rst_n = 1'b0;
    bus.i_desc_ready = 1'b1;
    bus.i_dma_done   = 1'b0;
    drive();
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    cyc();

    // First-transaction latency.
    push(0, 17'h10040);
    cyc();
    chk("t1_pop_q0", 32'(bus.o_fifo_rd), 32'h1);
    chk("t1_no_valid_yet", 32'(bus.o_desc_valid), 32'd0);
    cyc();
    chk("t1_valid", 32'(bus.o_desc_valid), 32'd1);
    chk("t1_data", 32'(bus.o_desc_data), 32'h10040);
    chk("t1_chn", 32'(bus.o_desc_chn), 32'd0);
    cyc();
    chk("t1_valid_drop", 32'(bus.o_desc_valid), 32'd0);
    repeat (2) cyc();
    bus.i_dma_done = 1'b1;
    cyc();
    bus.i_dma_done = 1'b0;
    chk("t1_idle_busy", 32'(bus.o_busy), 32'd0);
    chk("t1_idle_grant", 32'(bus.o_grant), 32'd0);

    foreach (tbl[i]) begin
      if (tbl[i].push_ch >= 0) push(tbl[i].push_ch, tbl[i].push_d);
      if (tbl[i].exp_ch >= 0) serve(tbl[i].exp_ch, tbl[i].exp_d, 2);
    end

    // HOLD: queue 3 runs dry mid-packet, queue 0 must wait.
    push(3, 17'h00010);
    serve(3, 17'h00010, 1);
    chk("hold_busy", 32'(bus.o_busy), 32'd1);
    push(0, L8);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("hold_no_pop_%0d", i), 32'(bus.o_fifo_rd), 32'd0);
      chk($sformatf("hold_grant_%0d", i), 32'(bus.o_grant), 32'h8);
    end
    push(3, 17'h10004);
    cyc();
    chk("hold_refetch_q3", 32'(bus.o_fifo_rd), 32'h8);
    serve(3, 17'h10004, 1);
    serve(0, L8, 1);

    // Zero-length last descriptor: popped, never offered.
    push(2, 17'h10000);
    cyc();
    chk("zl_pop_q2", 32'(bus.o_fifo_rd), 32'h4);
    cyc();
    chk("zl_no_valid", 32'(bus.o_desc_valid), 32'd0);
    chk("zl_idle", 32'(bus.o_busy), 32'd0);
    chk("zl_grant", 32'(bus.o_grant), 32'd0);
    chk("zl_q2_drained", 32'(q[2].size()), 32'd0);
    bus.i_dma_done = 1'b1;
    cyc();
    bus.i_dma_done = 1'b0;
    chk("done_in_idle", 32'(bus.o_busy), 32'd0);

    // Done during ISSUE is ignored.
    bus.i_desc_ready = 1'b0;
    push(1, L8);
    cyc(); cyc();
    chk("iss_valid", 32'(bus.o_desc_valid), 32'd1);
    bus.i_dma_done = 1'b1;
    cyc();
    bus.i_dma_done = 1'b0;
    chk("iss_hold_valid", 32'(bus.o_desc_valid), 32'd1);
    bus.i_desc_ready = 1'b1;
    cyc();
    chk("iss_accept", 32'(bus.o_desc_valid), 32'd0);
    cyc(); cyc();
    chk("iss_still_waiting", 32'(bus.o_busy), 32'd1);
    bus.i_dma_done = 1'b1;
    cyc();
    bus.i_dma_done = 1'b0;
    chk("iss_release", 32'(bus.o_busy), 32'd0);

    // Reset in WAIT_DONE, then pointer restarts at channel 0.
    push(2, L8);
    cyc(); cyc();
    chk("rst_valid", 32'(bus.o_desc_valid), 32'd1);
    cyc();
    chk("rst_wait_busy", 32'(bus.o_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_idle_outputs("midrst");
    cyc();
    rst_n = 1'b1;
    push(3, L8);
    push(0, L8);
    serve(0, L8, 1);
    serve(3, L8, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
